// File: rtl/stream_pkg.sv
// Shared stream helpers: lane-index sizing and keep-mask bit searches.
package stream_pkg;

  localparam int KEEP_MAX_W = 32;

  function automatic int lane_idx_w(input int ratio);
    return (ratio > 2) ? $clog2(ratio) : 1;
  endfunction

  localparam int LANE_IDX_W_MAX = lane_idx_w(KEEP_MAX_W);

  function automatic int highest_set(input logic [KEEP_MAX_W-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < KEEP_MAX_W; i++) begin
      r = v[i] ? i : r;
    end
    return r;
  endfunction

  function automatic int lowest_set(input logic [KEEP_MAX_W-1:0] v);
    int r;
    r = 0;
    for (int i = KEEP_MAX_W - 1; i >= 0; i--) begin
      r = v[i] ? i : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_downsize_if.sv
// Wide-in / narrow-out handshake bundle of the stream downsizer.
interface stream_downsize_if #(
  parameter int T_DATA_WIDTH = 4,
  parameter int T_DATA_RATIO = 2
);
  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO];
  logic [T_DATA_RATIO-1:0] s_keep_i;
  logic                    s_last_i;
  logic                    s_valid_i;
  logic                    s_ready_o;
  logic [T_DATA_WIDTH-1:0] m_data_o;
  logic                    m_last_o;
  logic                    m_valid_o;
  logic                    m_ready_i;

  modport slave (
    input  s_data_i, s_keep_i, s_last_i, s_valid_i, m_ready_i,
    output s_ready_o, m_data_o, m_last_o, m_valid_o
  );

  modport master (
    output s_data_i, s_keep_i, s_last_i, s_valid_i, m_ready_i,
    input  s_ready_o, m_data_o, m_last_o, m_valid_o
  );
endinterface

// File: rtl/stream_downsize_keep_lane_finder.sv
// Combinational lane search over a keep mask: next lane after idx and the final lane.
// Sparse skipping of zero lanes only with STREAM_DOWNSIZE_SPARSE_KEEP_EN.
module keep_lane_finder
  import stream_pkg::*;
#(
  parameter int RATIO = 2,
  parameter int IDX_W = 1
) (
  input  logic [RATIO-1:0] keep,
  input  logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] next_idx,
  output logic [IDX_W-1:0] high_idx,
  output logic             none
);

  logic hit_s;

  // next lane to emit after idx, and whether idx already is the last one
  always_comb begin
    high_idx = IDX_W'(highest_set(KEEP_MAX_W'(keep)));
    hit_s    = 1'b0;
`ifdef STREAM_DOWNSIZE_SPARSE_KEEP_EN
    next_idx = idx;
    none     = 1'b1;
    // scan downward so the lowest set lane above idx wins
    for (int i = RATIO - 1; i >= 0; i--) begin
      hit_s    = keep[i] && (i > int'(idx));
      next_idx = hit_s ? IDX_W'(i) : next_idx;
      none     = none & ~hit_s;
    end
`else
    next_idx = idx + IDX_W'(1);
    none     = (idx >= high_idx);
`endif
  end

endmodule

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: emits kept lanes of each wide word, lane 0 first.
// Optional macro STREAM_DOWNSIZE_SPARSE_KEEP_EN allows non-contiguous keep masks.
module stream_downsize
  import stream_pkg::*;
#(
  parameter int T_DATA_WIDTH = 4,
  parameter int T_DATA_RATIO = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_downsize_if.slave bus
);

  localparam int IDX_W = (lane_idx_w(T_DATA_RATIO) < LANE_IDX_W_MAX)
                         ? lane_idx_w(T_DATA_RATIO) : LANE_IDX_W_MAX;

  logic                    full_r;
  logic [IDX_W-1:0]        idx_r;
  logic [T_DATA_WIDTH-1:0] buf_data_r [T_DATA_RATIO];
  logic [T_DATA_RATIO-1:0] buf_keep_r;
  logic                    buf_last_r;

  logic [IDX_W-1:0] next_idx_s;
  logic [IDX_W-1:0] high_idx_s;
  logic             none_s;
  logic             final_s;
  logic [IDX_W-1:0] first_lane_s;
  logic             s_ready_s;
  logic             in_xfer_s;
  logic             out_xfer_s;

  keep_lane_finder #(
    .RATIO (T_DATA_RATIO),
    .IDX_W (IDX_W)
  ) u_finder (
    .keep     (buf_keep_r),
    .idx      (idx_r),
    .next_idx (next_idx_s),
    .high_idx (high_idx_s),
    .none     (none_s)
  );

  // start lane of an incoming word
  always_comb begin
`ifdef STREAM_DOWNSIZE_SPARSE_KEEP_EN
    first_lane_s = IDX_W'(lowest_set(KEEP_MAX_W'(bus.s_keep_i)));
`else
    first_lane_s = '0;
`endif
  end

  assign final_s    = none_s | (idx_r == high_idx_s);
  assign s_ready_s  = ~full_r | (bus.m_ready_i & final_s);
  assign in_xfer_s  = bus.s_valid_i & s_ready_s;
  assign out_xfer_s = full_r & bus.m_ready_i;

  // holding register: load on input transfer, step lanes on output transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r     <= 1'b0;
      idx_r      <= '0;
      buf_keep_r <= '0;
      buf_last_r <= 1'b0;
      for (int i = 0; i < T_DATA_RATIO; i++) begin
        buf_data_r[i] <= '0;
      end
    end else if (in_xfer_s) begin
      // an all-zero keep word is absorbed without ever going valid
      full_r     <= |bus.s_keep_i;
      idx_r      <= first_lane_s;
      buf_keep_r <= bus.s_keep_i;
      buf_last_r <= bus.s_last_i;
      for (int i = 0; i < T_DATA_RATIO; i++) begin
        buf_data_r[i] <= bus.s_data_i[i];
      end
    end else if (out_xfer_s) begin
      if (final_s) begin
        full_r <= 1'b0;
      end else begin
        idx_r <= next_idx_s;
      end
    end
  end

  assign bus.s_ready_o = s_ready_s;
  assign bus.m_valid_o = full_r;
  assign bus.m_data_o  = buf_data_r[idx_r];
  assign bus.m_last_o  = full_r & buf_last_r & final_s;

endmodule

// File: tb/tb_stream_downsize.sv
// Directed scoreboard bench for stream_downsize with 8-bit lanes, ratio 4.
module tb_stream_downsize;

  localparam int W = 8;
  localparam int R = 4;
`ifdef STREAM_DOWNSIZE_SPARSE_KEEP_EN
  localparam int SPARSE_BEATS = 2;
`else
  localparam int SPARSE_BEATS = 3;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stream_downsize_if #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) bus ();

  stream_downsize #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          tests = 0;
  int          fails = 0;
  int          beats = 0;
  logic [W:0]  sb [$];
  logic        beat_seen;
  logic        acc_seen;
  logic [31:0] cur_data;
  logic [3:0]  cur_keep;
  logic        cur_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic [31:0] data, input logic [3:0] keep,
                       input logic last);
    cur_data      = data;
    cur_keep      = keep;
    cur_last      = last;
    bus.s_valid_i = valid;
    bus.s_keep_i  = keep;
    bus.s_last_i  = last;
    for (int i = 0; i < R; i++) bus.s_data_i[i] = data[i*W +: W];
  endtask

  // Reference model: which lanes a word yields, and where last lands
  task automatic push_word();
    int hi;
    hi = -1;
    for (int i = 0; i < R; i++) if (cur_keep[i]) hi = i;
    for (int i = 0; i <= hi; i++) begin
`ifdef STREAM_DOWNSIZE_SPARSE_KEEP_EN
      if (cur_keep[i])
`endif
      sb.push_back({(cur_last && (i == hi)), cur_data[i*W +: W]});
    end
  endtask

  task automatic tick();
    logic [W:0] e;
    @(negedge clk);
    beat_seen = bus.m_valid_o && bus.m_ready_i;
    acc_seen  = bus.s_valid_i && bus.s_ready_o;
    if (beat_seen) begin
      beats++;
      if (sb.size() == 0) begin
        chk("unexpected_beat", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("beat_data", 32'(bus.m_data_o), 32'(e[W-1:0]));
        chk("beat_last", 32'(bus.m_last_o), 32'(e[W]));
      end
    end else if (bus.m_valid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(bus.m_valid_o), 32'd0);
      end else begin
        chk("stall_data", 32'(bus.m_data_o), 32'(sb[0][W-1:0]));
        chk("stall_last", 32'(bus.m_last_o), 32'(sb[0][W]));
      end
    end
    if (acc_seen) begin
      if (cur_keep == 4'd0) chk("last_with_empty_keep", 32'(cur_last), 32'd0);
      push_word();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while (sb.size() != 0 && g < 32) begin
      tick();
      g++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [3:0] pat;
    int         g;
    pat           = 4'b1001;
    rst_n         = 1'b0;
    bus.m_ready_i = 1'b0;
    drive(1'b0, 32'd0, 4'd0, 1'b0);
    #12;
    chk("rst_valid", 32'(bus.m_valid_o), 32'd0);
    chk("rst_last",  32'(bus.m_last_o),  32'd0);
    chk("rst_data",  32'(bus.m_data_o),  32'd0);
    chk("rst_ready", 32'(bus.s_ready_o), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // full word, consecutive beats one cycle after acceptance
    bus.m_ready_i = 1'b1;
    beats = 0;
    drive(1'b1, 32'h44332211, 4'hf, 1'b1);
    tick();
    chk("t1_accept", 32'(acc_seen), 32'd1);
    drive(1'b0, 32'd0, 4'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_consecutive", 32'(beat_seen), 32'd1);
    end
    tick();
    chk("t1_no_extra", 32'(beat_seen), 32'd0);
    chk("t1_beats", 32'(beats), 32'd4);

    // back-to-back words, second accepted in the first word's final-lane cycle
    beats = 0;
    drive(1'b1, 32'hA3A2A1A0, 4'hf, 1'b0);
    tick();
    chk("t2_accept_a", 32'(acc_seen), 32'd1);
    drive(1'b1, 32'hB3B2B1B0, 4'h3, 1'b1);
    g = 0;
    do begin
      tick();
      chk("t2_no_bubble", 32'(beat_seen), 32'd1);
      g++;
    end while (!acc_seen && g < 8);
    chk("t2_accept_b_cycle", 32'(g), 32'd4);
    drive(1'b0, 32'd0, 4'd0, 1'b0);
    g = 0;
    while (sb.size() != 0 && g < 8) begin
      tick();
      chk("t2_no_bubble", 32'(beat_seen), 32'd1);
      g++;
    end
    chk("t2_beats", 32'(beats), 32'd6);
    tick();
    chk("t2_no_extra", 32'(beat_seen), 32'd0);

    // downstream stalls with ready pattern 1,0,0,1
    beats = 0;
    bus.m_ready_i = 1'b0;
    drive(1'b1, 32'hC3C2C1C0, 4'hf, 1'b1);
    tick();
    chk("t3_accept", 32'(acc_seen), 32'd1);
    drive(1'b0, 32'd0, 4'd0, 1'b0);
    g = 0;
    while (sb.size() != 0 && g < 32) begin
      bus.m_ready_i = pat[g % 4];
      tick();
      g++;
    end
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);
    chk("t3_beats", 32'(beats), 32'd4);
    bus.m_ready_i = 1'b1;
    tick();
    chk("t3_no_extra", 32'(beat_seen), 32'd0);

    // keep with an interior hole
    beats = 0;
    drive(1'b1, 32'hD3D2D1D0, 4'b0101, 1'b1);
    tick();
    drive(1'b0, 32'd0, 4'd0, 1'b0);
    drain("t4_drain");
    chk("t4_beats", 32'(beats), 32'(SPARSE_BEATS));

    // empty keep is swallowed, next word is normal
    drive(1'b1, 32'h99999999, 4'd0, 1'b0);
    tick();
    chk("t5_accept", 32'(acc_seen), 32'd1);
    drive(1'b0, 32'd0, 4'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_no_valid", 32'(bus.m_valid_o), 32'd0);
    end
    beats = 0;
    drive(1'b1, 32'hF3F2F1F0, 4'hf, 1'b0);
    tick();
    drive(1'b0, 32'd0, 4'd0, 1'b0);
    drain("t5_drain");
    chk("t5_beats", 32'(beats), 32'd4);

    // reset in the middle of a word
    beats = 0;
    drive(1'b1, 32'hE3E2E1E0, 4'hf, 1'b1);
    tick();
    drive(1'b0, 32'd0, 4'd0, 1'b0);
    tick();
    tick();
    chk("t6_beats_before_rst", 32'(beats), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(bus.m_valid_o), 32'd0);
    chk("t6_ready", 32'(bus.s_ready_o), 32'd1);
    chk("t6_last",  32'(bus.m_last_o),  32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    beats = 0;
    drive(1'b1, 32'h57565554, 4'hf, 1'b1);
    tick();
    drive(1'b0, 32'd0, 4'd0, 1'b0);
    drain("t6_drain");
    chk("t6_beats_after", 32'(beats), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stream_downsize.md
# stream_downsize

Wide-to-narrow stream converter: accepts one wide word of `T_DATA_RATIO` lanes with a per-lane keep mask and emits the kept lanes one at a time, lane 0 first, on a narrow valid/ready stream. It is the transmit-side counterpart of the narrow-to-wide upsizer and restores the original beat stream from the upsizer's wide words. It sits between a wide datapath or FIFO and a narrow link.

## Interface
Parameters:
- `T_DATA_WIDTH`, 4, width of one lane or narrow beat.
- `T_DATA_RATIO`, 2, lanes per wide word; ≥2.

Ports:
- `clk`  in  1  sole clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `s_data_i`  in  `[T_DATA_WIDTH-1:0]` × `[T_DATA_RATIO-1:0]` (unpacked)  wide word; lane i is `s_data_i[i]`.
- `s_keep_i`  in  `T_DATA_RATIO`  bit i=1 means lane i is valid.
- `s_last_i`  in  1  the wide word ends a packet.
- `s_valid_i`  in  1  wide word valid.
- `s_ready_o`  out  1  the block can accept a wide word.
- `m_data_o`  out  `T_DATA_WIDTH`  narrow beat.
- `m_last_o`  out  1  last beat of the packet.
- `m_valid_o`  out  1  narrow beat valid.
- `m_ready_i`  in  1  downstream accepts the beat.

## Operation
- Holding register stores the data, keep and last of one wide word. It also holds lane index `idx` (width $clog2(T_DATA_RATIO), min 1) and a `full` flag.
- States:
  - EMPTY (`full`=0): `s_ready_o`=1, `m_valid_o`=0.
  - SEND (`full`=1): `m_valid_o`=1, `m_data_o`=`buf[idx]`.
- An input transfer occurs when `s_valid_i` and `s_ready_o` are both high.
  - Load the register and set `idx` to the first kept lane.
  - If `s_keep_i`=0, the word is dropped: the state stays EMPTY and nothing is emitted. Upstream must not send last with keep=0; the bench flags this case.
- On an output transfer (`m_valid_o` and `m_ready_i` both high):
  - If `idx` is not the final kept lane, `idx` advances to the next kept lane.
  - Otherwise the word is done. The block goes to EMPTY, or, if a new word arrives in the same cycle, loads it and stays in SEND.
- `s_ready_o` = !full OR (m_ready_i AND idx is final kept lane). This gives back-to-back words with no bubble.
- `m_last_o` = full AND buf_last AND (idx is final kept lane). It is 0 otherwise.
- "Final kept lane" is the highest set bit of the buffered keep.
- Data is not altered and keep is never output.
- Beats of a word with k kept lanes leave in k consecutive cycles when `m_ready_i` is held high.
- Held outputs stay stable while `m_valid_o`=1 and `m_ready_i`=0.

## Timing
- Reset (asynchronous assert, synchronous release): `full`=0, `idx`=0, buffer=0.
  - Outputs after reset: `m_valid_o`=0, `m_last_o`=0, `m_data_o`=0, `s_ready_o`=1.
- Latency: the first kept lane appears on `m_data_o` in the cycle after the input transfer. It is registered; there is no combinational path from `s_data_i`.
- `s_ready_o` depends combinationally on `m_ready_i`; no other combinational input-to-output path exists.
- Throughput: one narrow beat per cycle with no gaps between words.
- Reset asserted mid-word discards the buffered word, and no `m_last_o` is produced.
- `idx` never wraps past `T_DATA_RATIO-1`.

## Configuration
- `STREAM_DOWNSIZE_SPARSE_KEEP_EN` defined:
  - Keep may be non-contiguous.
  - The start lane is the lowest set bit; advance goes to the next set bit above `idx`.
  - Interior zero lanes are skipped.
- Not defined:
  - Keep is treated as a length.
  - The start lane is 0; lanes 0..(highest set bit) are emitted sequentially, including interior zero lanes.
  - A word with keep=0 is still dropped.

## Structure
- Shared package `stream_pkg` holds:
  - the lane index width constant and a helper function `lane_idx_w(ratio)`;
  - a `highest_set` function, reused by the upsizer bench.
- One sub-module `keep_lane_finder`:
  - combinational;
  - given keep and the current index, returns the next set lane, a "none" flag and the highest set lane;
  - under the macro-off case it degenerates to idx+1.

## Test plan
All scenarios use W=8, R=4.
- Word {0x44,0x33,0x22,0x11} (lane 0 = 0x11), keep=4'b1111, last=1, `m_ready_i`=1 → beats 0x11, 0x22, 0x33, 0x44 in 4 consecutive cycles starting one cycle after acceptance; `m_last_o` high only on 0x44.
- Two words in sequence, keep=4'b1111 then keep=4'b0011 with last → 6 beats with no bubble; `s_ready_o` high in the final-lane cycle of word 1; last on beat 6.
- `m_ready_i` toggles 1,0,0,1 → `m_data_o` and `m_last_o` hold stable during stalls; no beat lost or duplicated.
- keep=4'b0101, last=1:
  - macro defined: beats lane 0 and lane 2, last on lane 2;
  - macro undefined: lanes 0, 1, 2, last on lane 2.
- keep=4'b0000, no last → accepted, no `m_valid_o`; the next word is emitted normally.
- `rst_n` pulsed low after the 2nd beat of a keep=4'b1111 word → `m_valid_o`=0 immediately, `s_ready_o`=1; the next word starts at lane 0.
